// File: rtl/masterqp_ctrl.sv
// -----------------------------------------------------------------------------
// masterqp_ctrl
//
// Per-slice master-QP sequencer for the decoder rate-control path.
// A slice is started by a one-cycle slice_start pulse which loads the clamped
// slice initial QP and the block count. The first block always issues the
// initial QP. Every subsequent block first consumes one delta (or a flatness
// override) and then issues the clamped result over a valid/ready handshake.
// After the last block's handshake slice_done pulses for one cycle.
// A slice_start in any state aborts the running slice and reloads.
//
// Optional feature macro: MASTERQP_CTRL_STATS_EN
//   defined     : qp_stall_cycles counts ISSUE cycles with masterQp_ready low,
//                 saturating, cleared by rst and slice_start.
//   not defined : qp_stall_cycles is tied to zero, no counter is built.
//
// Ports
//   clk                       : clock
//   rst                       : asynchronous active-high reset
//   bits_per_component_coded  : 0=8bpc, 1=10bpc, 2=12bpc, 3 treated as 8bpc
//   slice_start               : one-cycle slice start / abort-and-reload pulse
//   init_qp                   : slice initial QP (sampled on slice_start)
//   blocks_in_slice           : block count (sampled on slice_start, 0 -> 1)
//   delta_qp / flat_override / flat_qp : per-block update, sampled with
//                               delta_valid & delta_ready
//   delta_valid / delta_ready : delta handshake
//   masterQp / masterQp_valid / masterQp_ready : issue handshake
//   slice_done                : one-cycle pulse after the last handshake
//   qp_stall_cycles           : stall statistic (see macro above)
// -----------------------------------------------------------------------------
module masterqp_ctrl #(
   parameter int QP_W    = 8,
   parameter int DELTA_W = 6,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                bits_per_component_coded,
   input  logic                      slice_start,
   input  logic signed [QP_W-1:0]    init_qp,
   input  logic [CNT_W-1:0]          blocks_in_slice,
   input  logic signed [DELTA_W-1:0] delta_qp,
   input  logic                      flat_override,
   input  logic signed [QP_W-1:0]    flat_qp,
   input  logic                      delta_valid,
   output logic                      delta_ready,
   output logic signed [QP_W-1:0]    masterQp,
   output logic                      masterQp_valid,
   input  logic                      masterQp_ready,
   output logic                      slice_done,
   output logic [CNT_W-1:0]          qp_stall_cycles
);

   // One guard bit above the QP width so the add and the clamp compares
   // never wrap.
   localparam int SUM_W = QP_W + 1;

   localparam logic signed [SUM_W-1:0] QP_MAX     = SUM_W'(72);
   localparam logic signed [SUM_W-1:0] QP_MIN_8B  = SUM_W'(16);
   localparam logic signed [SUM_W-1:0] QP_MIN_10B = SUM_W'(0);
   localparam logic signed [SUM_W-1:0] QP_MIN_12B = SUM_W'(-16);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_ACCUM = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic signed [QP_W-1:0]  r_qp;
   logic [CNT_W-1:0]        r_blk_cnt;
   logic                    r_valid;
   logic                    r_dready;
   logic                    r_done;

   logic signed [QP_W-1:0]  w_qp_next;
   logic [CNT_W-1:0]        w_cnt_next;
   logic                    w_valid_next;
   logic                    w_dready_next;
   logic                    w_done_next;

   logic signed [SUM_W-1:0] w_min_qp;
   logic signed [SUM_W-1:0] w_init_ext;
   logic signed [SUM_W-1:0] w_flat_ext;
   logic signed [SUM_W-1:0] w_qp_ext;
   logic signed [SUM_W-1:0] w_delta_ext;
   logic signed [SUM_W-1:0] w_sum;
   logic                    w_issue_hs;
   logic                    w_delta_hs;
   logic                    w_last_blk;

   function automatic logic signed [QP_W-1:0] clamp_qp(
      input logic signed [SUM_W-1:0] x,
      input logic signed [SUM_W-1:0] lo
   );
      logic signed [SUM_W-1:0] y;
      if (x > QP_MAX) begin
         y = QP_MAX;
      end else if (x < lo) begin
         y = lo;
      end else begin
         y = x;
      end
      return QP_W'(y);
   endfunction

   // Lower legal QP bound for the coded bit depth; encoding 3 falls back
   // to the 8 bpc range.
   always_comb begin
      case (bits_per_component_coded)
         2'd1:    w_min_qp = QP_MIN_10B;
         2'd2:    w_min_qp = QP_MIN_12B;
         default: w_min_qp = QP_MIN_8B;
      endcase
   end

   assign w_init_ext  = {init_qp[QP_W-1], init_qp};
   assign w_flat_ext  = {flat_qp[QP_W-1], flat_qp};
   assign w_qp_ext    = {r_qp[QP_W-1], r_qp};
   assign w_delta_ext = {{(SUM_W-DELTA_W){delta_qp[DELTA_W-1]}}, delta_qp};
   assign w_sum       = w_qp_ext + w_delta_ext;

   // valid is implied by ISSUE, ready by ACCUM
   assign w_issue_hs = (r_state == S_ISSUE) && masterQp_ready;
   assign w_delta_hs = (r_state == S_ACCUM) && delta_valid;
   assign w_last_blk = (r_blk_cnt == CNT_W'(1));

   // -------------------------------------------------------------------------
   // State register (plus the datapath and registered outputs)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_qp      <= '0;
         r_blk_cnt <= '0;
         r_valid   <= 1'b0;
         r_dready  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_qp      <= w_qp_next;
         r_blk_cnt <= w_cnt_next;
         r_valid   <= w_valid_next;
         r_dready  <= w_dready_next;
         r_done    <= w_done_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. slice_start wins over every other event.
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      if (slice_start) begin
         w_state_next = S_ISSUE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_next = S_IDLE;
            S_ISSUE: begin
               if (w_issue_hs) begin
                  w_state_next = w_last_blk ? S_IDLE : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (delta_valid) begin
                  w_state_next = S_ISSUE;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output / datapath next values. The handshake outputs are decoded from the
   // next state so that they come straight out of flops.
   // -------------------------------------------------------------------------
   always_comb begin
      w_qp_next   = r_qp;
      w_cnt_next  = r_blk_cnt;
      w_done_next = 1'b0;
      if (slice_start) begin
         // Abort-and-reload: any pending issue is dropped, no slice_done.
         w_qp_next  = clamp_qp(w_init_ext, w_min_qp);
         w_cnt_next = (blocks_in_slice == '0) ? CNT_W'(1) : blocks_in_slice;
      end else begin
         if (w_issue_hs) begin
            w_cnt_next  = r_blk_cnt - CNT_W'(1);
            w_done_next = w_last_blk;
         end
         if (w_delta_hs) begin
            w_qp_next = flat_override ? clamp_qp(w_flat_ext, w_min_qp)
                                      : clamp_qp(w_sum, w_min_qp);
         end
      end
      w_valid_next  = (w_state_next == S_ISSUE);
      w_dready_next = (w_state_next == S_ACCUM);
   end

   assign masterQp       = r_qp;
   assign masterQp_valid = r_valid;
   assign delta_ready    = r_dready;
   assign slice_done     = r_done;

   // -------------------------------------------------------------------------
   // Optional stall statistic
   // -------------------------------------------------------------------------
`ifdef MASTERQP_CTRL_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (slice_start) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_ISSUE) && !masterQp_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign qp_stall_cycles = r_stall_cnt;
`else
   assign qp_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_masterqp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_masterqp_ctrl
//
// Scoreboard bench for masterqp_ctrl. The slice driver computes every
// expected masterQp from the QP rules (clamp of init, clamp of qp+delta,
// clamp of flat_qp) with integer arithmetic and queues it; an independent
// monitor pops and compares on every issue handshake and also checks the
// slice_done pulse and output stability while stalled.
// -----------------------------------------------------------------------------
module tb_masterqp_ctrl;

   logic              clk;
   logic              rst;
   logic [1:0]        bits_per_component_coded;
   logic              slice_start;
   logic signed [7:0] init_qp;
   logic [15:0]       blocks_in_slice;
   logic signed [5:0] delta_qp;
   logic              flat_override;
   logic signed [7:0] flat_qp;
   logic              delta_valid;
   logic              delta_ready;
   logic signed [7:0] masterQp;
   logic              masterQp_valid;
   logic              masterQp_ready;
   logic              slice_done;
   logic [15:0]       qp_stall_cycles;

   typedef struct {
      int qp;
      bit last;
   } exp_t;

   exp_t exp_q[$];
   int   st_d[$];
   int   st_f[$];
   int   st_fq[$];

   int checks    = 0;
   int failures  = 0;
   int done_seen = 0;
   int ready_mode = 0;   // 0 always ready, 1 random, 2 held low

   masterqp_ctrl #(.QP_W(8), .DELTA_W(6), .CNT_W(16)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .bits_per_component_coded (bits_per_component_coded),
      .slice_start              (slice_start),
      .init_qp                  (init_qp),
      .blocks_in_slice          (blocks_in_slice),
      .delta_qp                 (delta_qp),
      .flat_override            (flat_override),
      .flat_qp                  (flat_qp),
      .delta_valid              (delta_valid),
      .delta_ready              (delta_ready),
      .masterQp                 (masterQp),
      .masterQp_valid           (masterQp_valid),
      .masterQp_ready           (masterQp_ready),
      .slice_done               (slice_done),
      .qp_stall_cycles          (qp_stall_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // Legal range [minQp, 72]; minQp from bit depth, encoding 3 acts as 8 bpc.
   function automatic int model_clamp(input int x, input int bpc);
      int lo;
      lo = (bpc == 1) ? 0 : ((bpc == 2) ? -16 : 16);
      if (x > 72) return 72;
      if (x < lo) return lo;
      return x;
   endfunction

   task automatic push_delta(input int d, input int f, input int fq);
      st_d.push_back(d);
      st_f.push_back(f);
      st_fq.push_back(fq);
   endtask

   // Sink: drives masterQp_ready a little after each rising edge.
   initial begin
      masterQp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       masterQp_ready = 1'b1;
            1:       masterQp_ready = ($urandom_range(0, 3) != 0);
            default: masterQp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: samples on the falling edge, where outputs and the inputs for
   // the coming rising edge are both stable.
   initial begin
      bit               done_exp;
      bit               stall_prev;
      logic signed [7:0] qp_prev;
      exp_t             e;
      done_exp   = 1'b0;
      stall_prev = 1'b0;
      qp_prev    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            done_exp   = 1'b0;
            stall_prev = 1'b0;
            continue;
         end
         if (slice_done) done_seen++;
         if (done_exp || slice_done) begin
            check(slice_done == done_exp, "slice_done", int'(slice_done), int'(done_exp));
         end
         done_exp = 1'b0;
         if (stall_prev) begin
            check(masterQp_valid && (masterQp == qp_prev), "hold_stable",
                  int'(masterQp), int'(qp_prev));
         end
         stall_prev = masterQp_valid && !masterQp_ready && !slice_start;
         qp_prev    = masterQp;
         if (masterQp_valid && masterQp_ready && !slice_start) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_issue", int'(masterQp), -999);
            end else begin
               e = exp_q.pop_front();
               check(int'(masterQp) == e.qp, "masterQp", int'(masterQp), e.qp);
               done_exp = e.last;
            end
         end
      end
   end

   // Runs one slice. sync=0 starts right at the current time (+1) so the
   // caller can hit the same cycle as an issue handshake. abort_k returns
   // right after accepting delta number abort_k.
   task automatic run_slice(input bit sync, input int bpc, input int init, input int nblk,
                            input int abort_k, input bit stall, input bit junk);
      int   mqp;
      int   neff;
      int   d;
      int   f;
      int   fq;
      int   tmo;
      int   d0;
      int   prev_mode;
      exp_t e;
      neff = (nblk < 1) ? 1 : nblk;
      if (sync) @(posedge clk);
      #1;
      delta_valid              = 1'b0;
      bits_per_component_coded = 2'(bpc);
      init_qp                  = 8'(init);
      blocks_in_slice          = 16'(nblk);
      prev_mode                = ready_mode;
      if (stall) ready_mode = 2;
      slice_start = 1'b1;
      exp_q.delete();
      mqp    = model_clamp(init, bpc);
      e.qp   = mqp;
      e.last = (neff == 1);
      exp_q.push_back(e);
      d0 = done_seen;
      @(posedge clk);
      #1;
      slice_start = 1'b0;
      check(masterQp_valid == 1'b1, "start_latency", int'(masterQp_valid), 1);
      if (stall) begin
         repeat (5) @(posedge clk);
         #1;
         check(masterQp_valid == 1'b1, "stall_valid", int'(masterQp_valid), 1);
`ifdef MASTERQP_CTRL_STATS_EN
         check(qp_stall_cycles == 16'd5, "stall_count", int'(qp_stall_cycles), 5);
`else
         check(qp_stall_cycles == 16'd0, "stall_count", int'(qp_stall_cycles), 0);
`endif
         ready_mode = prev_mode;
      end
      for (int k = 1; k < neff; k++) begin
         tmo = 0;
         forever begin
            @(negedge clk);
            if (delta_ready) break;
            tmo++;
            if (tmo > 400) break;
            // Garbage offered outside ACCUM must be ignored.
            if (junk && ($urandom_range(0, 2) == 0)) begin
               delta_valid   = 1'b1;
               delta_qp      = 6'($urandom);
               flat_override = 1'($urandom);
               flat_qp       = 8'($urandom);
            end else begin
               delta_valid = 1'b0;
            end
         end
         if (!delta_ready) begin
            delta_valid = 1'b0;
            check(1'b0, "delta_ready_timeout", 0, 1);
            return;
         end
         delta_valid = 1'b0;
         if (junk) repeat ($urandom_range(0, 2)) @(negedge clk);
         if (st_d.size() > 0) begin
            d  = st_d.pop_front();
            f  = st_f.pop_front();
            fq = st_fq.pop_front();
         end else begin
            d  = int'($urandom_range(0, 63)) - 32;
            f  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            fq = int'($urandom_range(0, 255)) - 128;
         end
         delta_qp      = 6'(d);
         flat_override = (f != 0);
         flat_qp       = 8'(fq);
         delta_valid   = 1'b1;
         @(posedge clk);
         mqp    = (f != 0) ? model_clamp(fq, bpc) : model_clamp(mqp + d, bpc);
         e.qp   = mqp;
         e.last = (k == neff - 1);
         exp_q.push_back(e);
         if (k == abort_k) return;
         #1;
         delta_valid = 1'b0;
         check(masterQp_valid == 1'b1, "delta_latency", int'(masterQp_valid), 1);
      end
      tmo = 0;
      while (((done_seen == d0) || (exp_q.size() != 0)) && (tmo < 400)) begin
         @(negedge clk);
         tmo++;
      end
      check((done_seen == d0 + 1) && (exp_q.size() == 0), "slice_end",
            done_seen - d0, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst                      = 1'b1;
      bits_per_component_coded = 2'd0;
      slice_start              = 1'b0;
      init_qp                  = '0;
      blocks_in_slice          = '0;
      delta_qp                 = '0;
      flat_override            = 1'b0;
      flat_qp                  = '0;
      delta_valid              = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check(masterQp == 8'sd0, "rst_masterQp", int'(masterQp), 0);
      check(masterQp_valid == 1'b0, "rst_valid", int'(masterQp_valid), 0);
      check(delta_ready == 1'b0, "rst_delta_ready", int'(delta_ready), 0);
      check(slice_done == 1'b0, "rst_slice_done", int'(slice_done), 0);
      check(qp_stall_cycles == 16'd0, "rst_stall", int'(qp_stall_cycles), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check(masterQp_valid == 1'b0, "idle_no_valid", int'(masterQp_valid), 0);

      // Basic sequence 30, 35, 31
      ready_mode = 0;
      push_delta(5, 0, 0);
      push_delta(-4, 0, 0);
      run_slice(1, 0, 30, 3, -1, 0, 0);
      // Lower clamp on init and on accumulation: 16, 16
      push_delta(-8, 0, 0);
      run_slice(1, 0, 10, 2, -1, 0, 0);
      // 12 bpc lower bound
      run_slice(1, 2, -20, 1, -1, 0, 0);
      // Upper clamp: 70, 72
      push_delta(31, 0, 0);
      run_slice(1, 0, 70, 2, -1, 0, 0);
      // Flat override: 30, 72, 40
      push_delta(1, 1, 80);
      push_delta(1, 1, 40);
      run_slice(1, 0, 30, 3, -1, 0, 0);
      // blocks_in_slice = 0 behaves as one block; 10 bpc floor
      run_slice(1, 1, -5, 0, -1, 0, 0);
      // Encoding 3 uses the 8 bpc range
      push_delta(-20, 0, 0);
      run_slice(1, 3, 20, 2, -1, 0, 0);
      // Stall: ready low for 5 ISSUE cycles
      push_delta(0, 0, 0);
      run_slice(1, 1, 5, 2, -1, 1, 0);
      // Abort in the same cycle as a mid-slice issue handshake, then reload
      push_delta(1, 0, 0);
      push_delta(2, 0, 0);
      run_slice(1, 0, 40, 5, 2, 0, 0);
      push_delta(3, 0, 0);
      run_slice(0, 0, 50, 2, -1, 0, 0);

      // Asynchronous reset in the middle of ISSUE
      ready_mode = 2;
      @(posedge clk);
      #1;
      bits_per_component_coded = 2'd0;
      init_qp         = 8'sd44;
      blocks_in_slice = 16'd3;
      slice_start     = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      slice_start = 1'b0;
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check(masterQp == 8'sd0, "arst_masterQp", int'(masterQp), 0);
      check(masterQp_valid == 1'b0, "arst_valid", int'(masterQp_valid), 0);
      check(delta_ready == 1'b0, "arst_delta_ready", int'(delta_ready), 0);
      check(slice_done == 1'b0, "arst_slice_done", int'(slice_done), 0);
      check(qp_stall_cycles == 16'd0, "arst_stall", int'(qp_stall_cycles), 0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      ready_mode = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check((masterQp_valid == 1'b0) && (delta_ready == 1'b0), "idle_after_rst",
               int'(masterQp_valid), 0);
      end

      // Randomized slices with random sink readiness and ignored garbage deltas
      ready_mode = 1;
      for (int s = 0; s < 40; s++) begin
         run_slice(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 6)), -1, 0, 1);
      end

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
